fb_port_arbiter: RTL and testbench

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_port_arbiter.sv | 95 +++++++++
 tb/tb_fb_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: one single-port RAM shared by a JPEG writer that
// cannot be stalled and a host reader. The writer always wins the port.
module fb_port_arbiter #(
   parameter int ASZ = 17
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           frame_start,
   input  logic [ASZ-1:0] wr_addr,
   input  logic [7:0]     wr_data,
   input  logic           wr_we,
   input  logic           wr_done,
   input  logic           rd_req,
   input  logic [ASZ-1:0] rd_addr,
   output logic           rd_gnt,
   output logic           rd_valid,
   output logic [7:0]     rd_data,
   output logic [ASZ-1:0] ram_addr,
   output logic [7:0]     ram_wdata,
   output logic           ram_we,
   input  logic [7:0]     ram_rdata,
   output logic           frame_ready,
   output logic           capturing,
   output logic           wr_err,
   output logic [ASZ-1:0] frame_bytes
);

   typedef enum logic [1:0] {IDLE, CAPTURE, READY} state_t;

   state_t         state;
   logic [ASZ-1:0] addr_shadow;
   logic           wr_acc;

   // reset_n gates the port so nothing reaches the RAM while reset is held
   always_comb begin
      wr_acc    = reset_n & capturing & wr_we;
      rd_gnt    = reset_n & rd_req & ~wr_acc;
      ram_we    = wr_acc;
      ram_wdata = wr_data;
      rd_data   = ram_rdata;
      if (wr_acc)
         ram_addr = wr_addr;
      else if (rd_gnt)
         ram_addr = rd_addr;
      else
         ram_addr = addr_shadow;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         capturing   <= 1'b0;
         frame_ready <= 1'b0;
         wr_err      <= 1'b0;
         frame_bytes <= '0;
         rd_valid    <= 1'b0;
         addr_shadow <= '0;
      end else begin
         rd_valid    <= rd_gnt;
         addr_shadow <= ram_addr;

         // a stray write in the same cycle as frame_start still flags an error
         if (frame_start)
            wr_err <= 1'b0;
         if (wr_we && state != CAPTURE)
            wr_err <= 1'b1;

         case (state)
            IDLE, READY: begin
               if (frame_start) begin
                  state       <= CAPTURE;
                  capturing   <= 1'b1;
                  frame_ready <= 1'b0;
                  frame_bytes <= '0;
               end
            end
            CAPTURE: begin
               if (wr_acc && frame_bytes != '1)
                  frame_bytes <= frame_bytes + ASZ'(1);
               if (wr_done) begin
                  state       <= READY;
                  capturing   <= 1'b0;
                  frame_ready <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               capturing   <= 1'b0;
               frame_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed frame scenarios plus random
// traffic, compared cycle by cycle against a behavioural model.
module tb_fb_port_arbiter;

   localparam int ASZ   = 10;
   localparam int DEPTH = 1 << ASZ;
   localparam int MAXB  = DEPTH - 1;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           frame_start;
   logic [ASZ-1:0] wr_addr;
   logic [7:0]     wr_data;
   logic           wr_we;
   logic           wr_done;
   logic           rd_req;
   logic [ASZ-1:0] rd_addr;
   logic           rd_gnt;
   logic           rd_valid;
   logic [7:0]     rd_data;
   logic [ASZ-1:0] ram_addr;
   logic [7:0]     ram_wdata;
   logic           ram_we;
   logic [7:0]     ram_rdata;
   logic           frame_ready;
   logic           capturing;
   logic           wr_err;
   logic [ASZ-1:0] frame_bytes;

   int n_cmp = 0;
   int n_err = 0;

   fb_port_arbiter #(.ASZ(ASZ)) dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we), .wr_done(wr_done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
      .rd_data(rd_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_we(ram_we), .ram_rdata(ram_rdata), .frame_ready(frame_ready),
      .capturing(capturing), .wr_err(wr_err), .frame_bytes(frame_bytes)
   );

   always #5 clk = ~clk;

   // single-port RAM, one-cycle read latency
   logic [7:0] ram [0:DEPTH-1];
   logic       ram_init;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h00;
      end else begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         ram_rdata <= ram[ram_addr];
      end
   end

   // behavioural model: frame phase flags, counters, expected memory image
   bit       m_cap, m_rdy, m_err, m_valid;
   int       m_bytes;
   int       m_vaddr, m_shadow;
   bit [7:0] m_mem [0:DEPTH-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cap = 0; m_rdy = 0; m_err = 0; m_valid = 0;
      m_bytes = 0; m_vaddr = 0; m_shadow = 0;
   endtask

   // one clock cycle: drive, check at negedge against model, advance model
   task automatic cyc(input bit fs, input bit we, input int wa, input int wd,
                      input bit done, input bit rr, input int ra);
      bit acc, gnt;
      int eaddr;
      frame_start = fs; wr_we = we; wr_addr = ASZ'(wa); wr_data = 8'(wd);
      wr_done = done; rd_req = rr; rd_addr = ASZ'(ra);
      @(negedge clk);
      acc   = m_cap && we;
      gnt   = rr && !acc;
      eaddr = acc ? wa : (gnt ? ra : m_shadow);
      check("capturing",   32'(capturing),   32'(m_cap));
      check("frame_ready", 32'(frame_ready), 32'(m_rdy));
      check("wr_err",      32'(wr_err),      32'(m_err));
      check("frame_bytes", 32'(frame_bytes), 32'(m_bytes));
      check("rd_gnt",      32'(rd_gnt),      32'(gnt));
      check("ram_we",      32'(ram_we),      32'(acc));
      check("ram_addr",    32'(ram_addr),    32'(eaddr));
      check("rd_valid",    32'(rd_valid),    32'(m_valid));
      if (acc)     check("ram_wdata", 32'(ram_wdata), 32'(wd & 255));
      if (m_valid) check("rd_data",   32'(rd_data),   32'(m_mem[m_vaddr]));
      m_shadow = eaddr;
      m_valid  = gnt;
      m_vaddr  = ra;
      if (acc) begin
         m_mem[wa] = 8'(wd);
         if (m_bytes < MAXB) m_bytes++;
      end
      if (fs) m_err = 0;
      if (we && !m_cap) m_err = 1;
      if (m_cap) begin
         if (done) begin m_cap = 0; m_rdy = 1; end
      end else if (fs) begin
         m_cap = 1; m_rdy = 0; m_bytes = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   // assert reset between edges with a write and a read pending
   task automatic mid_reset();
      wr_we = 1'b1; rd_req = 1'b1; wr_addr = ASZ'(7); rd_addr = ASZ'(9);
      #2 reset_n = 1'b0;
      #1;
      check("rst_capturing",   32'(capturing),   0);
      check("rst_frame_ready", 32'(frame_ready), 0);
      check("rst_wr_err",      32'(wr_err),      0);
      check("rst_frame_bytes", 32'(frame_bytes), 0);
      check("rst_rd_valid",    32'(rd_valid),    0);
      check("rst_ram_we",      32'(ram_we),      0);
      check("rst_rd_gnt",      32'(rd_gnt),      0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; frame_start = 0; wr_we = 0; wr_addr = '0; wr_data = '0;
      wr_done = 0; rd_req = 0; rd_addr = '0; ram_init = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1 ram_init = 1'b0;
      mid_reset();

      // stray write in IDLE, then frame_start clears the error
      cyc(0, 1, 5, 8'h55, 0, 0, 0);
      idle(1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle(1);

      // full 640-byte frame, pattern data = address
      for (int i = 0; i < 640; i++) cyc(0, 1, i, i & 255, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      idle(1);
      check("bytes_640", 32'(frame_bytes), 640);
      for (int i = 0; i < 640; i++) check("ram_pattern", 32'(ram[i]), 32'(i & 255));

      // READY: four back-to-back reads
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, i);
      idle(2);

      // CAPTURE: read blocked by five writes, granted on the sixth cycle
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 'h100 + i, 'hC0 + i, 0, 1, 'h10);
      cyc(0, 0, 0, 0, 0, 1, 'h10);
      idle(1);

      // write coincident with wr_done
      cyc(0, 1, 'h1FF, 'hA5, 1, 0, 0);
      idle(2);
      check("ram_1ff", 32'(ram['h1FF]), 32'hA5);

      // frame_bytes saturation
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH + 6; i++) cyc(0, 1, $urandom_range(0, MAXB), $urandom_range(0, 255), 0, 0, 0);
      check("bytes_sat", 32'(frame_bytes), 32'(MAXB));
      cyc(0, 0, 0, 0, 1, 0, 0);

      // reset mid-capture after 100 writes
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) cyc(0, 1, i, 'h33, 0, 0, 0);
      mid_reset();
      for (int i = 0; i < 3; i++) cyc(0, 1, 'h20 + i, 'h77, 0, 1, i);
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle(1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit fs, we;
         fs = ($urandom_range(0, 39) == 0);
         we = fs ? 1'b0 : 1'($urandom_range(0, 1));
         cyc(fs, we, $urandom_range(0, MAXB), $urandom_range(0, 255),
             ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, MAXB));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
